// File: rtl/uart_rx_frame_checker_if.sv
// uart_rx_frame_checker_if: sampler/controller-facing signal bundle of the UART RX frame checker.
interface uart_rx_frame_checker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
);
    logic                  frame_start;
    logic                  bit_valid;
    logic                  bit_value;
    logic                  cfg_par_en;
    logic [1:0]            cfg_par_mode;
    logic                  cfg_two_stop;
    logic                  cnt_clr;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  frame_done;
    logic                  data_valid;
    logic                  par_err;
    logic                  stop_err;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stop_err_cnt;

    modport master (
        output frame_start, bit_valid, bit_value, cfg_par_en, cfg_par_mode, cfg_two_stop, cnt_clr,
        input  p_data, frame_done, data_valid, par_err, stop_err, busy, par_err_cnt, stop_err_cnt
    );

    modport slave (
        input  frame_start, bit_valid, bit_value, cfg_par_en, cfg_par_mode, cfg_two_stop, cnt_clr,
        output p_data, frame_done, data_valid, par_err, stop_err, busy, par_err_cnt, stop_err_cnt
    );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// uart_rx_frame_checker: deserialises a UART frame, checks parity/stop bits, counts errors.
module uart_rx_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input logic clk,
    input logic rst,
    uart_rx_frame_checker_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

    state_t                st, nxt;
    logic [BW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] sh;
    logic                  acc, par_en_l, two_l;
    logic [1:0]            mode_l;
    logic                  par_err, stop_err, frame_done, data_valid, busy;
    logic [CNT_WIDTH-1:0]  par_cnt, stop_cnt;
    logic                  bv, fin, exp_par, stop_nx;

    // a bit strobe coinciding with frame_start belongs to no frame
    assign bv      = bus.bit_valid & ~bus.frame_start;
    assign fin     = bv & (st == STOP2 | (st == STOP1 & ~two_l));
    assign exp_par = mode_l[1] ? ~mode_l[0] : acc ^ mode_l[0];
    assign stop_nx = stop_err | (bv & (st == STOP1 | st == STOP2) & ~bus.bit_value);

    always_ff @(posedge clk)
        if (rst) st <= IDLE;
        else     st <= nxt;

    always_comb begin
        nxt = st;
        if (bus.frame_start) nxt = DATA;
        else if (bus.bit_valid)
            case (st)
                DATA:    nxt = (cnt == BW'(DATA_WIDTH - 1)) ? (par_en_l ? PARITY : STOP1) : DATA;
                PARITY:  nxt = STOP1;
                STOP1:   nxt = two_l ? STOP2 : IDLE;
                STOP2:   nxt = IDLE;
                default: nxt = st;
            endcase
    end

    always_comb begin
        busy = st != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sh         <= '0;
            acc        <= 1'b0;
            par_en_l   <= 1'b0;
            mode_l     <= 2'b00;
            two_l      <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            frame_done <= 1'b0;
            data_valid <= 1'b0;
            par_cnt    <= '0;
            stop_cnt   <= '0;
        end else begin
            frame_done <= fin;
            data_valid <= fin & ~(par_err | stop_nx);
            if (bus.frame_start) begin
                cnt      <= '0;
                sh       <= '0;
                acc      <= 1'b0;
                par_err  <= 1'b0;
                stop_err <= 1'b0;
                par_en_l <= bus.cfg_par_en;
                mode_l   <= bus.cfg_par_mode;
                two_l    <= bus.cfg_two_stop;
            end else if (bv) begin
                if (st == DATA) begin
                    sh  <= {bus.bit_value, sh[DATA_WIDTH-1:1]};
                    acc <= acc ^ bus.bit_value;
                    cnt <= cnt + 1'b1;
                end
                if (st == PARITY) par_err <= bus.bit_value != exp_par;
                stop_err <= stop_nx;
            end
            if (bus.cnt_clr) par_cnt <= '0;
            else if (fin & par_err & ~&par_cnt) par_cnt <= par_cnt + 1'b1;
            if (bus.cnt_clr) stop_cnt <= '0;
            else if (fin & stop_nx & ~&stop_cnt) stop_cnt <= stop_cnt + 1'b1;
        end
    end

    assign bus.p_data       = sh;
    assign bus.frame_done   = frame_done;
    assign bus.data_valid   = data_valid;
    assign bus.par_err      = par_err;
    assign bus.stop_err     = stop_err;
    assign bus.busy         = busy;
    assign bus.par_err_cnt  = par_cnt;
    assign bus.stop_err_cnt = stop_cnt;
endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// tb_uart_rx_frame_checker: directed frames on an 8/8 and a 5/2 instance, scoreboard-checked at frame_done.
module tb_uart_rx_frame_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_frame_checker_if #(.DATA_WIDTH(8), .CNT_WIDTH(8)) ia ();
    uart_rx_frame_checker_if #(.DATA_WIDTH(5), .CNT_WIDTH(2)) ib ();

    uart_rx_frame_checker #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    uart_rx_frame_checker #(.DATA_WIDTH(5), .CNT_WIDTH(2)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

    typedef struct {
        logic [8:0] d;
        logic       dv, pe, se;
        int         pc, sc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int checks = 0;
    int failures = 0;
    int pc[2] = '{0, 0};
    int sc[2] = '{0, 0};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic drive(input bit s, input logic fs, input logic bv, input logic val, input logic clr);
        if (s) begin
            ib.frame_start = fs; ib.bit_valid = bv; ib.bit_value = val; ib.cnt_clr = clr;
        end else begin
            ia.frame_start = fs; ia.bit_valid = bv; ia.bit_value = val; ia.cnt_clr = clr;
        end
    endtask

    task automatic cfg(input bit s, input logic pen, input logic [1:0] mode, input logic two);
        if (s) begin
            ib.cfg_par_en = pen; ib.cfg_par_mode = mode; ib.cfg_two_stop = two;
        end else begin
            ia.cfg_par_en = pen; ia.cfg_par_mode = mode; ia.cfg_two_stop = two;
        end
    endtask

    task automatic step(input bit s, input logic fs, input logic bv, input logic val, input logic clr);
        @(negedge clk);
        drive(s, fs, bv, val, clr);
        @(negedge clk);
        drive(s, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // frame_start plus n data bits, left unfinished
    task automatic partial(input bit s, input logic [8:0] d, input int n);
        step(s, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step(s, 1'b0, 1'b1, d[i], 1'b0);
    endtask

    task automatic send_frame(input bit s, input logic [8:0] d, input logic pen, input logic [1:0] mode,
                              input logic two, input logic pbit, input logic s1, input logic s2,
                              input logic epe, input logic ese, input logic clr);
        int n;
        int mx;
        exp_t e;
        n  = s ? 5 : 8;
        mx = s ? 3 : 255;
        cfg(s, pen, mode, two);
        step(s, 1'b1, 1'b1, 1'b0, 1'b0);
        cfg(s, ~pen, ~mode, ~two);
        for (int i = 0; i < n; i++) step(s, 1'b0, 1'b1, d[i], 1'b0);
        if (pen) step(s, 1'b0, 1'b1, pbit, 1'b0);
        if (clr) begin
            pc[s] = 0; sc[s] = 0;
        end else begin
            if (epe && pc[s] < mx) pc[s]++;
            if (ese && sc[s] < mx) sc[s]++;
        end
        e.d  = s ? (d & 9'h1f) : (d & 9'hff);
        e.dv = ~(epe | ese);
        e.pe = epe;
        e.se = ese;
        e.pc = pc[s];
        e.sc = sc[s];
        if (s) qb.push_back(e);
        else   qa.push_back(e);
        step(s, 1'b0, 1'b1, s1, two ? 1'b0 : clr);
        if (two) step(s, 1'b0, 1'b1, s2, clr);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ia.data_valid && !ia.frame_done) chk("a_dv_without_done", 1, 0);
        if (ia.frame_done) begin
            if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_p_data", int'(ia.p_data), int'(e.d));
                chk("a_data_valid", int'(ia.data_valid), int'(e.dv));
                chk("a_par_err", int'(ia.par_err), int'(e.pe));
                chk("a_stop_err", int'(ia.stop_err), int'(e.se));
                chk("a_par_cnt", int'(ia.par_err_cnt), e.pc);
                chk("a_stop_cnt", int'(ia.stop_err_cnt), e.sc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ib.data_valid && !ib.frame_done) chk("b_dv_without_done", 1, 0);
        if (ib.frame_done) begin
            if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_p_data", int'(ib.p_data), int'(e.d));
                chk("b_data_valid", int'(ib.data_valid), int'(e.dv));
                chk("b_par_err", int'(ib.par_err), int'(e.pe));
                chk("b_stop_err", int'(ib.stop_err), int'(e.se));
                chk("b_par_cnt", int'(ib.par_err_cnt), e.pc);
                chk("b_stop_cnt", int'(ib.stop_err_cnt), e.sc);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_a_outs"}, int'({ia.p_data, ia.frame_done, ia.data_valid, ia.par_err, ia.stop_err, ia.busy}), 0);
        chk({tag, "_a_cnts"}, int'({ia.par_err_cnt, ia.stop_err_cnt}), 0);
        chk({tag, "_b_outs"}, int'({ib.p_data, ib.frame_done, ib.data_valid, ib.par_err, ib.stop_err, ib.busy}), 0);
        chk({tag, "_b_cnts"}, int'({ib.par_err_cnt, ib.stop_err_cnt}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cfg(1'b0, 1'b0, 2'b00, 1'b0);
        cfg(1'b1, 1'b0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("reset");
        // 8N1 0xA5, then 8E1 good and bad parity
        send_frame(1'b0, 9'h0a5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 9'h0a5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 9'h0a5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // 8O2 0x01 good, then bad second stop; mark mode with parity 0
        send_frame(1'b0, 9'h001, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 9'h001, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(1'b0, 9'h001, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 9'h0ff, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        // aborted frame, then good 0x3C
        partial(1'b0, 9'h0ff, 4);
        chk("a_busy_mid", int'(ia.busy), 1);
        send_frame(1'b0, 9'h03c, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("a_busy_idle", int'(ia.busy), 0);
        chk("a_hold_p_data", int'(ia.p_data), 8'h3c);
        // 5E1 0x13 parity 1 passes; then saturation and clear on the 2-bit counters
        send_frame(1'b1, 9'h013, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++)
            send_frame(1'b1, 9'h013, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(1'b1, 9'h013, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        // reset in the middle of a frame abandons it
        partial(1'b1, 9'h013, 3);
        chk("b_busy_mid", int'(ib.busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("midrst");
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_zero("post_rst_idle");
        repeat (4) @(negedge clk);
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_checker.md
Name: uart_rx_frame_checker

Overview:
Parametrised next-generation receive-side frame checker for the UART RX path. It consumes oversampled-and-decided serial bits from the RX sampler, deserialises DATA_WIDTH data bits LSB first, and accumulates parity serially. It then checks the parity bit in one of four modes and the 1 or 2 stop bits. Per-frame error flags, a validated parallel word, and saturating error counters are presented to the RX controller and register file.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CNT_WIDTH, 8, width of each saturating error counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
frame_start  input  1  one-cycle pulse from the start-bit detector; begins a new frame
bit_valid  input  1  one-cycle strobe; bit_value holds a decided sample
bit_value  input  1  sampled serial bit
cfg_par_en  input  1  1 = parity bit present in the frame
cfg_par_mode  input  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
cfg_two_stop  input  1  1 = two stop bits, 0 = one stop bit
cnt_clr  input  1  synchronous clear of both error counters
p_data  output  DATA_WIDTH  received word
frame_done  output  1  one-cycle pulse at end of frame
data_valid  output  1  one-cycle pulse with frame_done when no error occurred
par_err  output  1  parity error of last frame
stop_err  output  1  stop-bit error of last frame (any stop bit = 0)
busy  output  1  high while a frame is in progress
par_err_cnt  output  CNT_WIDTH  saturating parity-error count
stop_err_cnt  output  CNT_WIDTH  saturating stop-error count

Behaviour:
- Reset (rst=1 at clk edge):
  - All outputs go to 0 and the FSM enters IDLE.
  - Reset mid-frame abandons the frame with no frame_done.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- Configuration latch:
  - cfg_par_en, cfg_par_mode and cfg_two_stop are latched on frame_start.
  - Changes to these inputs mid-frame have no effect until the next frame_start.
- frame_start, valid in any state:
  - Clears the bit counter, the shift register and the parity accumulator.
  - Clears par_err and stop_err, then goes to DATA.
  - In a non-IDLE state it aborts the current frame silently: no frame_done, no counter update.
  - A bit_valid in the same cycle as frame_start is ignored.
- IDLE: bit_valid is ignored; busy=0.
- DATA: each bit_valid does the following:
  - Shifts bit_value into p_data from the MSB side, so the first bit ends at p_data[0] after DATA_WIDTH bits.
  - XORs bit_value into the accumulator.
  - Increments the bit counter.
  - After the DATA_WIDTH-th bit, goes to PARITY if the latched par_en=1, else STOP1.
- PARITY: on bit_valid, compares bit_value against the expected bit, then goes to STOP1.
  - Expected bit by mode: even = accumulator; odd = ~accumulator; mark = 1; space = 0.
  - par_err is set if the bit mismatches.
- STOP1: on bit_valid, stop_err is set if bit_value=0; goes to STOP2 if two_stop, else the frame ends.
- STOP2: on bit_valid, stop_err is OR-set if bit_value=0; the frame ends.
- Frame end:
  - On the clock edge sampling the final stop bit: frame_done<=1, data_valid<=~(par_err_next|stop_err_next), FSM->IDLE.
  - Both pulses last exactly one cycle.
  - Latency: frame_done is high in the cycle following the final bit_valid.
  - par_err, stop_err and p_data hold their values until the next frame_start or rst.
  - A frame_start arriving in the cycle after the end is accepted normally.
- Counters:
  - On frame end, each counter increments by 1 if its flag is set, saturating at 2^CNT_WIDTH-1.
  - cnt_clr has priority over a coincident increment: the counter becomes 0 and that error is not counted.
- busy: 1 in DATA, PARITY, STOP1 and STOP2.

Test Plan:
- Reset, then 8N1 frame with data 0xA5 (bits 1,0,1,0,0,1,0,1) and stop=1 -> 1 cycle after the stop strobe: frame_done=1, data_valid=1, p_data=0xA5, par_err=0, stop_err=0.
- 8E1 with 0xA5 and parity bit 0 -> no error. Repeat with parity bit 1 -> par_err=1, data_valid=0, par_err_cnt=1.
- 8O2 with 0x01 and parity 0 -> pass. Repeat with second stop=0 -> stop_err=1, stop_err_cnt=1. Mark mode with parity 0 -> par_err=1.
- frame_start after 4 data bits, then a full good frame 0x3C -> exactly one frame_done, p_data=0x3C, counters unchanged.
- CNT_WIDTH=2: 5 parity-error frames -> par_err_cnt saturates at 3. cnt_clr on the cycle of a 6th error -> counter reads 0.
- DATA_WIDTH=5, 5E1, bits 1,1,0,0,1, parity 1; rst asserted during DATA of the next frame -> first frame passes with p_data=5'h13; after rst all outputs are 0 and no frame_done occurs.
